// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ALU, branch target, destination select,
// an iterative shift-add multiplier for MULT, and the EX/MEM pipeline latch.
module ex_stage #(
    parameter int W        = 32,
    parameter int MUL_ITER = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] pc_plus4,
    input  logic [W-1:0] read_data1,
    input  logic [W-1:0] read_data2,
    input  logic [W-1:0] sign_ext_imm,
    input  logic [4:0]   rt,
    input  logic [4:0]   rd,
    input  logic [1:0]   wb_ctrl,
    input  logic [2:0]   m_ctrl,
    input  logic         reg_dst,
    input  logic         alu_src,
    input  logic [1:0]   alu_op,
    output logic         stall,
    output logic [W-1:0] alu_result,
    output logic [W-1:0] write_data,
    output logic [4:0]   write_reg,
    output logic [1:0]   wb_ctrl_out,
    output logic         branch,
    output logic         mem_read,
    output logic         mem_write,
    output logic         zero,
    output logic [W-1:0] branch_target
);

    localparam int          CW         = $clog2(MUL_ITER + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_ITER - 1);
    localparam logic [5:0]  FUNCT_ADD  = 6'h20;
    localparam logic [5:0]  FUNCT_SUB  = 6'h22;
    localparam logic [5:0]  FUNCT_AND  = 6'h24;
    localparam logic [5:0]  FUNCT_OR   = 6'h25;
    localparam logic [5:0]  FUNCT_SLT  = 6'h2A;
    localparam logic [5:0]  FUNCT_MULT = 6'h18;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_state_t;

    mul_state_t    mul_state_r;
    logic [W-1:0]  mcand_r;
    logic [W-1:0]  mplier_r;
    logic [W-1:0]  product_r;
    logic [CW-1:0] mul_cnt_r;

    logic [W-1:0]  op_b_s;
    logic [5:0]    funct_s;
    logic          is_mult_s;
    logic [W-1:0]  result_s;
    logic [4:0]    write_reg_s;
    logic [W-1:0]  branch_target_s;
    logic          latch_valid_s;
    logic          stall_s;

    // Single-cycle ALU; MULT is produced by the multiplier, so it yields 0 here.
    function automatic logic [W-1:0] alu_calc(
        input logic [1:0]   op,
        input logic [5:0]   funct,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [W-1:0] r;
        r = {W{1'b0}};
        case (op)
            2'b00: r = a + b;
            2'b01: r = a - b;
            2'b10: begin
                case (funct)
                    FUNCT_ADD: r = a + b;
                    FUNCT_SUB: r = a - b;
                    FUNCT_AND: r = a & b;
                    FUNCT_OR:  r = a | b;
                    FUNCT_SLT: r = ($signed(a) < $signed(b)) ? {{(W-1){1'b0}}, 1'b1} : {W{1'b0}};
                    default:   r = {W{1'b0}};
                endcase
            end
            default: r = {W{1'b0}};
        endcase
        return r;
    endfunction

    // Operand select, result mux, latch-enable and stall decode.
    always_comb begin
        op_b_s          = alu_src ? sign_ext_imm : read_data2;
        funct_s         = sign_ext_imm[5:0];
        is_mult_s       = (alu_op == 2'b10) && (funct_s == FUNCT_MULT);
        write_reg_s     = reg_dst ? rd : rt;
        branch_target_s = pc_plus4 + {sign_ext_imm[W-3:0], 2'b00};
        if (mul_state_r == DONE) begin
            result_s = product_r;
        end else begin
            result_s = alu_calc(alu_op, funct_s, read_data1, op_b_s);
        end
        case (mul_state_r)
            IDLE:    latch_valid_s = in_valid && !is_mult_s;
            BUSY:    latch_valid_s = 1'b0;
            DONE:    latch_valid_s = in_valid;
            default: latch_valid_s = 1'b0;
        endcase
        stall_s = !rst && in_valid && is_mult_s && (mul_state_r != DONE);
    end

    assign stall = stall_s;

    // Multiply sequencer: one multiplier bit per cycle, MUL_ITER cycles in BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_state_r <= IDLE;
            mcand_r     <= {W{1'b0}};
            mplier_r    <= {W{1'b0}};
            product_r   <= {W{1'b0}};
            mul_cnt_r   <= {CW{1'b0}};
        end else begin
            case (mul_state_r)
                IDLE: begin
                    if (in_valid && is_mult_s) begin
                        mcand_r     <= read_data1;
                        mplier_r    <= op_b_s;
                        product_r   <= {W{1'b0}};
                        mul_cnt_r   <= {CW{1'b0}};
                        mul_state_r <= BUSY;
                    end else begin
                        mul_state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (mplier_r[0]) begin
                        product_r <= product_r + mcand_r;
                    end else begin
                        product_r <= product_r;
                    end
                    mcand_r   <= {mcand_r[W-2:0], 1'b0};
                    mplier_r  <= {1'b0, mplier_r[W-1:1]};
                    mul_cnt_r <= mul_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (mul_cnt_r == CNT_LAST) begin
                        mul_state_r <= DONE;
                    end else begin
                        mul_state_r <= BUSY;
                    end
                end
                DONE:    mul_state_r <= IDLE;
                default: mul_state_r <= IDLE;
            endcase
        end
    end

    // EX/MEM latch: loads a real result or a zero bubble every cycle.
    always_ff @(posedge clk) begin
        if (rst || !latch_valid_s) begin
            alu_result    <= {W{1'b0}};
            write_data    <= {W{1'b0}};
            write_reg     <= 5'd0;
            wb_ctrl_out   <= 2'b00;
            branch        <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            zero          <= 1'b0;
            branch_target <= {W{1'b0}};
        end else begin
            alu_result    <= result_s;
            write_data    <= read_data2;
            write_reg     <= write_reg_s;
            wb_ctrl_out   <= wb_ctrl;
            branch        <= m_ctrl[2];
            mem_read      <= m_ctrl[1];
            mem_write     <= m_ctrl[0];
            zero          <= (result_s == {W{1'b0}});
            branch_target <= branch_target_s;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, branch, load, multiply stall and reset.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] pc_plus4, read_data1, read_data2, sign_ext_imm;
    logic [4:0]  rt, rd;
    logic [1:0]  wb_ctrl;
    logic [2:0]  m_ctrl;
    logic        reg_dst, alu_src;
    logic [1:0]  alu_op;
    logic        stall;
    logic [31:0] alu_result, write_data, branch_target;
    logic [4:0]  write_reg;
    logic [1:0]  wb_ctrl_out;
    logic        branch, mem_read, mem_write, zero;

    int checks = 0;
    int errors = 0;

    ex_stage #(.W(32), .MUL_ITER(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pc_plus4(pc_plus4),
        .read_data1(read_data1), .read_data2(read_data2), .sign_ext_imm(sign_ext_imm),
        .rt(rt), .rd(rd), .wb_ctrl(wb_ctrl), .m_ctrl(m_ctrl), .reg_dst(reg_dst),
        .alu_src(alu_src), .alu_op(alu_op), .stall(stall), .alu_result(alu_result),
        .write_data(write_data), .write_reg(write_reg), .wb_ctrl_out(wb_ctrl_out),
        .branch(branch), .mem_read(mem_read), .mem_write(mem_write), .zero(zero),
        .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; pc_plus4 = 32'h0; read_data1 = 32'h0; read_data2 = 32'h0;
        sign_ext_imm = 32'h0; rt = 5'd0; rd = 5'd0; wb_ctrl = 2'b00; m_ctrl = 3'b000;
        reg_dst = 1'b0; alu_src = 1'b0; alu_op = 2'b00;
    endtask

    task automatic set_rtype(input logic [31:0] a, input logic [31:0] b, input logic [5:0] funct,
                             input logic [4:0] dst);
        clear_inputs();
        in_valid = 1'b1; read_data1 = a; read_data2 = b; sign_ext_imm = {26'd0, funct};
        alu_op = 2'b10; reg_dst = 1'b1; rd = dst; wb_ctrl = 2'b10;
    endtask

    function automatic logic [31:0] out_any();
        return {31'd0, |{alu_result, write_data, write_reg, wb_ctrl_out, branch,
                         mem_read, mem_write, zero, branch_target}};
    endfunction

    // Hold a presented mult through its stall window and check the final latch.
    task automatic mult_window(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 33; i++) begin
            chk({tag, "_stall"}, {31'd0, stall}, 32'd1);
            tick();
            chk({tag, "_bubble"}, out_any(), 32'd0);
        end
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        tick();
        chk({tag, "_result"}, alu_result, exp);
        chk({tag, "_write_reg"}, {27'd0, write_reg}, 32'd3);
        chk({tag, "_wb_ctrl"}, {30'd0, wb_ctrl_out}, 32'd2);
    endtask

    initial begin
        clear_inputs();
        // Reset with a mult presented: stall must stay low, outputs zero.
        rst = 1'b1;
        set_rtype(32'd6, 32'd7, 6'h18, 5'd3);
        #1;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        tick();
        tick();
        chk("reset_outputs", out_any(), 32'd0);
        chk("reset_stall2", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        clear_inputs();
        tick();

        // R-type add
        set_rtype(32'd5, 32'd7, 6'h20, 5'd9);
        #1;
        chk("add_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("add_result", alu_result, 32'd12);
        chk("add_zero", {31'd0, zero}, 32'd0);
        chk("add_write_reg", {27'd0, write_reg}, 32'd9);
        chk("add_wb_ctrl", {30'd0, wb_ctrl_out}, 32'd2);

        // beq
        clear_inputs();
        in_valid = 1'b1; read_data1 = 32'h10; read_data2 = 32'h10; alu_op = 2'b01;
        m_ctrl = 3'b100; pc_plus4 = 32'h100; sign_ext_imm = 32'd3;
        tick();
        chk("beq_zero", {31'd0, zero}, 32'd1);
        chk("beq_branch", {31'd0, branch}, 32'd1);
        chk("beq_target", branch_target, 32'h10C);

        // slt signed both orders
        set_rtype(32'hFFFF_FFFF, 32'd1, 6'h2A, 5'd8);
        tick();
        chk("slt_neg_lt", alu_result, 32'd1);
        set_rtype(32'd1, 32'hFFFF_FFFF, 6'h2A, 5'd8);
        tick();
        chk("slt_pos_ge", alu_result, 32'd0);
        chk("slt_zero", {31'd0, zero}, 32'd1);

        // and / or / sub
        set_rtype(32'hF0F0_1234, 32'h0FF0_FF00, 6'h24, 5'd1);
        tick();
        chk("and_result", alu_result, 32'h00F0_1200);
        set_rtype(32'hF0F0_1234, 32'h0FF0_FF00, 6'h25, 5'd1);
        tick();
        chk("or_result", alu_result, 32'hFFF0_FF34);
        set_rtype(32'd3, 32'd5, 6'h22, 5'd1);
        tick();
        chk("sub_wrap", alu_result, 32'hFFFF_FFFE);

        // lw
        clear_inputs();
        in_valid = 1'b1; alu_src = 1'b1; alu_op = 2'b00; read_data1 = 32'h1000;
        read_data2 = 32'h55; sign_ext_imm = 32'hFFFF_FFFC; reg_dst = 1'b0; rt = 5'd4; rd = 5'd17;
        m_ctrl = 3'b010; wb_ctrl = 2'b11;
        tick();
        chk("lw_addr", alu_result, 32'h0000_0FFC);
        chk("lw_write_reg", {27'd0, write_reg}, 32'd4);
        chk("lw_mem_read", {31'd0, mem_read}, 32'd1);
        chk("lw_wb_ctrl", {30'd0, wb_ctrl_out}, 32'd3);
        chk("lw_write_data", write_data, 32'h55);

        // Unknown funct and reserved alu_op give 0
        set_rtype(32'd5, 32'd7, 6'h3F, 5'd2);
        tick();
        chk("bad_funct", alu_result, 32'd0);
        chk("bad_funct_zero", {31'd0, zero}, 32'd1);
        set_rtype(32'd5, 32'd7, 6'h20, 5'd2);
        alu_op = 2'b11;
        tick();
        chk("reserved_op", alu_result, 32'd0);

        // Bubble when not valid
        set_rtype(32'd5, 32'd7, 6'h20, 5'd9);
        in_valid = 1'b0;
        tick();
        chk("bubble_outputs", out_any(), 32'd0);

        // mult 6x7, then an add immediately after DONE
        set_rtype(32'd6, 32'd7, 6'h18, 5'd3);
        #1;
        mult_window("mult_6x7", 32'd42);
        chk("mult_6x7_write_data", write_data, 32'd7);
        set_rtype(32'd5, 32'd7, 6'h20, 5'd9);
        #1;
        chk("post_mult_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("post_mult_add", alu_result, 32'd12);

        // mult 0xFFFFFFFF x 2
        set_rtype(32'hFFFF_FFFF, 32'd2, 6'h18, 5'd3);
        #1;
        mult_window("mult_neg", 32'hFFFF_FFFE);

        // Reset at BUSY iteration 10 with the mult still presented
        set_rtype(32'd5, 32'd9, 6'h18, 5'd3);
        #1;
        for (int i = 0; i < 11; i++) begin
            tick();
        end
        rst = 1'b1;
        #1;
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("midrst_outputs", out_any(), 32'd0);
        rst = 1'b0;
        #1;
        mult_window("mult_restart", 32'd45);
        clear_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes ID/EX latch fields and computes the ALU result, zero flag, branch target and destination register.
- Registers all results into an internal EX/MEM pipeline latch that feeds the memory stage directly.
- Adds an iterative shift-add multiplier for MULT, which stalls upstream stages while busy.

Parameters:
- W, 32, datapath width; only 32 is supported.
- MUL_ITER, 32, multiplier iterations (one operand bit per cycle); must equal W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  ID/EX holds a real instruction
- pc_plus4  in  32  PC+4 of the instruction
- read_data1  in  32  rs operand
- read_data2  in  32  rt operand
- sign_ext_imm  in  32  sign-extended immediate; bits [5:0] are funct
- rt  in  5  rt field
- rd  in  5  rd field
- wb_ctrl  in  2  {RegWrite, MemToReg}
- m_ctrl  in  3  {Branch, MemRead, MemWrite}
- reg_dst  in  1  1 = rd, 0 = rt
- alu_src  in  1  1 = immediate as operand B
- alu_op  in  2  00 add, 01 sub, 10 R-type by funct, 11 reserved
- stall  out  1  upstream must hold PC, IF/ID and ID/EX
- alu_result  out  32  registered
- write_data  out  32  registered read_data2
- write_reg  out  5  registered destination register
- wb_ctrl_out  out  2  registered
- branch  out  1  registered
- mem_read  out  1  registered
- mem_write  out  1  registered
- zero  out  1  registered; 1 when the ALU result is 0
- branch_target  out  32  registered pc_plus4 + (imm<<2)

Behaviour:
- Reset: all registered outputs are 0 and the FSM is IDLE. While rst=1, stall=0.
- Single-cycle ops: results appear on the outputs one edge after presentation.
- Operand B is sign_ext_imm when alu_src=1, otherwise read_data2.
- alu_op decode:
  - 00: A+B.
  - 01: A-B.
  - 10: decode by funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 0/1), 0x18 mult (low 32 bits of product). Any other funct gives result 0.
  - 11: result 0.
- Arithmetic wraps modulo 2^32; there is no overflow trap.
- MULT result: low 32 bits are identical for signed and unsigned, so the unsigned shift-add is used.
- zero = (result == 0), registered alongside alu_result.
- branch_target = pc_plus4 + (sign_ext_imm << 2), wraps modulo 2^32.
- write_reg = reg_dst ? rd : rt.
- Bubble: when in_valid=0, or during a multiply stall, the latch loads all outputs as 0.
- Multiply FSM states:
  - IDLE → BUSY when in_valid and the op is mult. Captures operands, clears the product and counter, latches a bubble.
  - BUSY: each cycle, if multiplier bit0 is set, product += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++. After MUL_ITER cycles, go to DONE. A bubble is latched every cycle.
  - DONE: latch the product with the instruction's control/write_reg fields, then go to IDLE.
- stall = in_valid && is_mult && state != DONE, combinational. A mult occupies EX for MUL_ITER+2 cycles and stall is high for MUL_ITER+1 of them.
- Upstream holds ID/EX inputs stable while stall=1. Inputs are not re-captured in BUSY.
- Reset mid-multiply: the FSM returns to IDLE and the outputs clear. If the mult is still presented after rst drops, it restarts from scratch.
- A non-mult instruction in the cycle after DONE executes normally, with no extra bubble.

Test Plan:
- R-type add: read_data1=5, read_data2=7, alu_op=10, funct=0x20, wb_ctrl=10, reg_dst=1, rd=9 → next edge alu_result=12, zero=0, write_reg=9, wb_ctrl_out=10, stall=0.
- beq: read_data1=read_data2=0x10, alu_op=01, m_ctrl=100, pc_plus4=0x100, imm=3 → zero=1, branch=1, branch_target=0x10C.
- slt signed: A=0xFFFFFFFF, B=1, funct=0x2A → alu_result=1. With A and B swapped → 0, zero=1.
- lw: alu_src=1, alu_op=00, A=0x1000, imm=0xFFFFFFFC, reg_dst=0, rt=4, m_ctrl=010, wb_ctrl=11 → alu_result=0xFFC, write_reg=4, mem_read=1.
- mult 6×7 (wb_ctrl=10, rd=3):
  - stall high for 33 consecutive cycles, with outputs all 0 during them.
  - Then alu_result=42, write_reg=3, wb_ctrl_out=10, stall=0.
  - Repeat with 0xFFFFFFFF×2 → 0xFFFFFFFE.
- Reset for 1 cycle at BUSY iteration 10 with the mult still presented → outputs 0 on the reset edge; after release, stall is high a full 33 cycles and the result is correct.
